hps_io_sequencer: RTL

Frame-level controller for the HPS general-purpose SPI word channel. It tracks io-enable framing, captures the first word of each frame as the command, and numbers the following words as data. It arbitrates which core-side client owns the frame and muxes the owning client's reply word back toward the SPI slave. It sits between the HPS interface (strobe, received word, enable level) and the core's command handlers.

---
 rtl/hps_io_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hps_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : hps_io_sequencer
// Brief   : HPS SPI word-channel frame sequencer: command capture, data-word
//           numbering, client arbitration and reply-word muxing.
// Revision: 1.0 - initial release
// ============================================================================
module hps_io_sequencer #(
    parameter int NUM_CLIENTS = 4,
    parameter int IDX_W       = 16
) (
    input  logic                     sync_clk,
    input  logic                     reset,
    input  logic                     io_en,
    input  logic                     io_strobe,
    input  logic [15:0]              word_rx,
    output logic [15:0]              cmd,
    output logic                     cmd_start,
    output logic                     data_valid,
    output logic [15:0]              data_word,
    output logic [IDX_W-1:0]         data_idx,
    output logic                     frame_end,
    input  logic [NUM_CLIENTS-1:0]   client_req,
    output logic [NUM_CLIENTS-1:0]   client_sel,
    input  logic [16*NUM_CLIENTS-1:0] client_tx,
    output logic [15:0]              word_tx,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_CMD = 2'd1,
        ST_CLAIM    = 2'd2,
        ST_DATA     = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_io_en_d;
    logic [IDX_W-1:0] r_cnt;

    logic                   w_rise;
    logic                   w_fall;
    logic                   w_strobe;
    logic                   w_accept;
    logic [NUM_CLIENTS-1:0] w_first_req;
    logic [15:0]            w_owner_tx;

    assign w_rise   = io_en & ~r_io_en_d;
    assign w_fall   = ~io_en & r_io_en_d;
    // A strobe coinciding with the falling edge belongs to no frame.
    assign w_strobe = io_strobe & io_en;
    assign w_accept = w_strobe & ~w_fall &
                      ((r_state == ST_CLAIM) || (r_state == ST_DATA));
    assign busy     = (r_state != ST_IDLE);

    always_comb begin
        w_first_req = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (client_req[i]) begin
                w_first_req    = '0;
                w_first_req[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_owner_tx = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (client_sel[i]) begin
                w_owner_tx = w_owner_tx | client_tx[16*i +: 16];
            end
        end
    end

    always_ff @(posedge sync_clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_io_en_d  <= 1'b0;
            r_cnt      <= '0;
            cmd        <= '0;
            cmd_start  <= 1'b0;
            data_valid <= 1'b0;
            data_word  <= '0;
            data_idx   <= '0;
            frame_end  <= 1'b0;
            client_sel <= '0;
            word_tx    <= '0;
        end else begin
            r_io_en_d  <= io_en;
            cmd_start  <= 1'b0;
            data_valid <= 1'b0;
            frame_end  <= 1'b0;
            word_tx    <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_WAIT_CMD;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT_CMD: begin
                    if (w_fall) begin
                        r_state    <= ST_IDLE;
                        frame_end  <= 1'b1;
                        client_sel <= '0;
                    end else if (w_strobe) begin
                        r_state   <= ST_CLAIM;
                        cmd       <= word_rx;
                        cmd_start <= 1'b1;
                    end
                end
                ST_CLAIM: begin
                    if (w_fall) begin
                        r_state    <= ST_IDLE;
                        frame_end  <= 1'b1;
                        client_sel <= '0;
                    end else begin
                        r_state    <= ST_DATA;
                        client_sel <= w_first_req;
                    end
                end
                ST_DATA: begin
                    if (w_fall) begin
                        r_state    <= ST_IDLE;
                        frame_end  <= 1'b1;
                        client_sel <= '0;
                    end else if (client_sel != '0) begin
                        word_tx <= w_owner_tx;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_accept) begin
                data_valid <= 1'b1;
                data_word  <= word_rx;
                data_idx   <= r_cnt;
                if (r_cnt != {IDX_W{1'b1}}) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
